// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder
// Upstream stage of a systolic matrix-multiply array. It buffers matrix A
// (A_ROWS x K_DIM) and matrix B (K_DIM x B_COLS). On start it clears the
// array accumulators for one cycle. It then streams skewed, zero-padded
// operands onto the array's row and column edges. It pulses done once every
// PE holds its final dot product.
// Optional feature: define FEEDER_DBLBUF_EN for two operand banks. The next
// matrices can then be loaded while a run is in progress.
// All outputs come straight from registers, so every output lags the FSM
// state by one cycle.
module systolic_operand_feeder #(
   parameter int DATA_WIDTH   = 8,
   parameter int A_ROWS       = 2,
   parameter int B_COLS       = 2,
   parameter int K_DIM        = 2,   // >= 1
   parameter int DRAIN_CYCLES = 1,   // >= 1, MAC register latency
   localparam int R_MAX = (A_ROWS > K_DIM) ? A_ROWS : K_DIM,
   localparam int C_MAX = (B_COLS > K_DIM) ? B_COLS : K_DIM,
   localparam int RW    = $clog2((R_MAX > 2) ? R_MAX : 2),
   localparam int CW    = $clog2((C_MAX > 2) ? C_MAX : 2)
) (
   input  logic                  clk,
   input  logic                  reset,        // async, active-low
   input  logic                  wr_en,
   input  logic                  wr_sel,       // 0 = A, 1 = B
   input  logic [RW-1:0]         wr_row,
   input  logic [CW-1:0]         wr_col,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_drop,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  array_rst_n,
   output logic [DATA_WIDTH-1:0] a_out [0:A_ROWS-1],
   output logic [DATA_WIDTH-1:0] b_out [0:B_COLS-1]
);

   localparam int T_FEED  = K_DIM + A_ROWS + B_COLS - 2;
   localparam int CNT_MAX = (T_FEED > DRAIN_CYCLES) ? T_FEED : DRAIN_CYCLES;
   localparam int CNTW    = $clog2(CNT_MAX + 1);
`ifdef FEEDER_DBLBUF_EN
   localparam int NBANK = 2;
`else
   localparam int NBANK = 1;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [CNTW-1:0]   cnt, cnt_nxt;
   logic              engaged;
   logic              start_ok;
   logic              wr_in_range;
   logic              wr_ok;
   logic              wr_bank;
   logic              rd_bank;
   logic [DATA_WIDTH-1:0] a_nxt [0:A_ROWS-1];
   logic [DATA_WIDTH-1:0] b_nxt [0:B_COLS-1];

   logic [DATA_WIDTH-1:0] a_mem [0:NBANK-1][0:A_ROWS-1][0:K_DIM-1];
   logic [DATA_WIDTH-1:0] b_mem [0:NBANK-1][0:K_DIM-1][0:B_COLS-1];

   // The registered busy output lags the state by one cycle. It is still
   // high in the cycle done pulses, and that cycle counts as part of the run.
   assign engaged  = (state != S_IDLE) || busy;
   assign start_ok = start && !engaged;

   assign wr_in_range = wr_sel ? ((int'(wr_row) < K_DIM)  && (int'(wr_col) < B_COLS))
                               : ((int'(wr_row) < A_ROWS) && (int'(wr_col) < K_DIM));

`ifdef FEEDER_DBLBUF_EN
   assign wr_ok   = wr_en && wr_in_range;
   assign rd_bank = ~wr_bank;

   // Swap banks when a run launches, so FEED reads the data just loaded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        wr_bank <= 1'b0;
      else if (start_ok) wr_bank <= ~wr_bank;
   end
`else
   assign wr_ok   = wr_en && wr_in_range && !engaged;
   assign wr_bank = 1'b0;
   assign rd_bank = 1'b0;
`endif

   // Operand storage write port.
   // NOTE: the operand RAM has no reset. Its contents are only meaningful
   // after a write, and a reset branch would stop it mapping to memory.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         for (int bk = 0; bk < NBANK; bk++) begin
            for (int i = 0; i < A_ROWS; i++)
               for (int k = 0; k < K_DIM; k++)
                  if (bk == int'(wr_bank) && !wr_sel && int'(wr_row) == i && int'(wr_col) == k)
                     a_mem[bk][i][k] <= wr_data;
            for (int k = 0; k < K_DIM; k++)
               for (int j = 0; j < B_COLS; j++)
                  if (bk == int'(wr_bank) && wr_sel && int'(wr_row) == k && int'(wr_col) == j)
                     b_mem[bk][k][j] <= wr_data;
         end
      end
   end

   // FSM state and the shared FEED/DRAIN cycle counter.
   // NOTE: clocked state uses non-blocking assignments, so every register
   // samples pre-edge values no matter how the blocks are ordered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic: CLEAR(1) -> FEED(T_FEED) -> DRAIN(DRAIN_CYCLES) -> DONE(1).
   // NOTE: defaults come first, so paths that do not assign a signal cannot
   // infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         S_IDLE: begin
            if (start_ok) begin
               state_nxt = S_CLEAR;
               cnt_nxt   = '0;
            end
         end
         S_CLEAR: begin
            state_nxt = S_FEED;
            cnt_nxt   = '0;
         end
         S_FEED: begin
            if (cnt == CNTW'(T_FEED - 1)) begin
               state_nxt = S_DRAIN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNTW'(1);
            end
         end
         S_DRAIN: begin
            if (cnt == CNTW'(DRAIN_CYCLES - 1)) begin
               state_nxt = S_DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNTW'(1);
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Skewed operand selection. Row i is delayed by i cycles and column j by
   // j cycles, and slots outside the matrix are zero-padded.
   always_comb begin
      for (int i = 0; i < A_ROWS; i++) a_nxt[i] = '0;
      for (int j = 0; j < B_COLS; j++) b_nxt[j] = '0;
      if (state == S_FEED) begin
         for (int bk = 0; bk < NBANK; bk++) begin
            if (bk == int'(rd_bank)) begin
               for (int i = 0; i < A_ROWS; i++)
                  for (int k = 0; k < K_DIM; k++)
                     if (int'(cnt) - i == k) a_nxt[i] = a_mem[bk][i][k];
               for (int j = 0; j < B_COLS; j++)
                  for (int k = 0; k < K_DIM; k++)
                     if (int'(cnt) - j == k) b_nxt[j] = b_mem[bk][k][j];
            end
         end
      end
   end

   // Output registers. The array accumulators are held cleared during reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < A_ROWS; i++) a_out[i] <= '0;
         for (int j = 0; j < B_COLS; j++) b_out[j] <= '0;
         array_rst_n <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         wr_drop     <= 1'b0;
      end else begin
         a_out       <= a_nxt;
         b_out       <= b_nxt;
         array_rst_n <= (state != S_CLEAR);
         busy        <= (state != S_IDLE);
         done        <= (state == S_DONE);
         wr_drop     <= wr_en && !wr_ok;
      end
   end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Testbench for systolic_operand_feeder: a default 2x2x2 instance and a
// 3x2 (K=4) instance. Each instance drives a small behavioural model of the
// systolic array. The bench compares the accumulated results with
// hand-computed or reference-model products.
module tb_systolic_operand_feeder;

`ifdef FEEDER_DBLBUF_EN
   localparam logic EXP_BUSY_DROP = 1'b0;
`else
   localparam logic EXP_BUSY_DROP = 1'b1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   // ---------------- instance 0: 2x2, K=2 ----------------
   logic       wr_en0, wr_sel0, start0;
   logic [0:0] wr_row0, wr_col0;
   logic [7:0] wr_data0;
   logic       wr_drop0, busy0, done0, arst0;
   logic [7:0] a_out0 [0:1];
   logic [7:0] b_out0 [0:1];

   systolic_operand_feeder dut0 (
      .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_sel(wr_sel0),
      .wr_row(wr_row0), .wr_col(wr_col0), .wr_data(wr_data0), .wr_drop(wr_drop0),
      .start(start0), .busy(busy0), .done(done0), .array_rst_n(arst0),
      .a_out(a_out0), .b_out(b_out0)
   );

   // ---------------- instance 1: 3x2, K=4 ----------------
   logic       wr_en1, wr_sel1, start1;
   logic [1:0] wr_row1, wr_col1;
   logic [7:0] wr_data1;
   logic       wr_drop1, busy1, done1, arst1;
   logic [7:0] a_out1 [0:2];
   logic [7:0] b_out1 [0:1];

   systolic_operand_feeder #(.A_ROWS(3), .B_COLS(2), .K_DIM(4)) dut1 (
      .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_sel(wr_sel1),
      .wr_row(wr_row1), .wr_col(wr_col1), .wr_data(wr_data1), .wr_drop(wr_drop1),
      .start(start1), .busy(busy1), .done(done1), .array_rst_n(arst1),
      .a_out(a_out1), .b_out(b_out1)
   );

   // Behavioural systolic arrays. Each PE adds a_left*b_top to its
   // accumulator, then passes a to the right and b downward.
   logic [15:0] c0 [0:1][0:1];
   logic [7:0]  ah0 [0:1][0:1];
   logic [7:0]  bv0 [0:1][0:1];
   always @(posedge clk or negedge arst0) begin
      if (!arst0) begin
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
               c0[i][j] <= '0; ah0[i][j] <= '0; bv0[i][j] <= '0;
            end
      end else begin
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
               ah0[i][j] <= (j == 0) ? a_out0[i] : ah0[i][(j == 0) ? 0 : j - 1];
               bv0[i][j] <= (i == 0) ? b_out0[j] : bv0[(i == 0) ? 0 : i - 1][j];
               c0[i][j]  <= c0[i][j] +
                            ((j == 0) ? a_out0[i] : ah0[i][(j == 0) ? 0 : j - 1]) *
                            ((i == 0) ? b_out0[j] : bv0[(i == 0) ? 0 : i - 1][j]);
            end
      end
   end

   logic [15:0] c1 [0:2][0:1];
   logic [7:0]  ah1 [0:2][0:1];
   logic [7:0]  bv1 [0:2][0:1];
   always @(posedge clk or negedge arst1) begin
      if (!arst1) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 2; j++) begin
               c1[i][j] <= '0; ah1[i][j] <= '0; bv1[i][j] <= '0;
            end
      end else begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 2; j++) begin
               ah1[i][j] <= (j == 0) ? a_out1[i] : ah1[i][(j == 0) ? 0 : j - 1];
               bv1[i][j] <= (i == 0) ? b_out1[j] : bv1[(i == 0) ? 0 : i - 1][j];
               c1[i][j]  <= c1[i][j] +
                            ((j == 0) ? a_out1[i] : ah1[i][(j == 0) ? 0 : j - 1]) *
                            ((i == 0) ? b_out1[j] : bv1[(i == 0) ? 0 : i - 1][j]);
            end
      end
   end

   int done_cnt0 = 0;
   always @(posedge clk) if (done0) done_cnt0 <= done_cnt0 + 1;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- instance 0 helpers ----------------
   logic [7:0] ma0 [0:1][0:1];
   logic [7:0] mb0 [0:1][0:1];
   int rec_a [0:15][0:1];
   int rec_b [0:15][0:1];
   int run_k;

   task automatic write0(input logic sel, input int row, input int col,
                         input logic [7:0] data, input logic exp_drop);
      wr_en0 = 1'b1; wr_sel0 = sel; wr_row0 = 1'(row); wr_col0 = 1'(col); wr_data0 = data;
      @(posedge clk); #1;
      wr_en0 = 1'b0;
      check($sformatf("wr_drop0 sel%0d r%0d c%0d", sel, row, col), 32'(wr_drop0), 32'(exp_drop));
   endtask

   task automatic load0();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++) begin
            write0(1'b0, r, c, ma0[r][c], 1'b0);
            write0(1'b1, r, c, mb0[r][c], 1'b0);
         end
   endtask

   // Launch a run on instance 0. Cycle k counts edges after the edge that
   // sampled start. If inj_k > 0, a write and a second start are pulsed in
   // cycle inj_k. If rst_k > 0, reset is asserted mid-cycle in cycle rst_k.
   task automatic run0(input int inj_k, input int rst_k);
      logic got_done;
      got_done = 1'b0;
      run_k    = 0;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k < 16)
            for (int i = 0; i < 2; i++) begin
               rec_a[k][i] = a_out0[i];
               rec_b[k][i] = b_out0[i];
            end
         if (k == 1) check("array_rst_n low in clear", 32'(arst0), 32'd0);
         if (k == 2) check("array_rst_n high after clear", 32'(arst0), 32'd1);
         if (inj_k > 0 && k == inj_k + 1) begin
            wr_en0 = 1'b0; start0 = 1'b0;
            check("wr_drop0 while busy", 32'(wr_drop0), 32'(EXP_BUSY_DROP));
         end
         if (inj_k > 0 && k == inj_k) begin
            wr_en0 = 1'b1; wr_sel0 = 1'b0; wr_row0 = 1'b0; wr_col0 = 1'b0; wr_data0 = 8'd99;
            start0 = 1'b1;
         end
         if (rst_k > 0 && k == rst_k) begin
            check("a_out0[0] nonzero before reset", 32'(a_out0[0] != 8'd0), 32'd1);
            #2 reset = 1'b0;
            #1;
            check("reset mid-run a_out0[0]", 32'(a_out0[0]), 32'd0);
            check("reset mid-run b_out0[0]", 32'(b_out0[0]), 32'd0);
            check("reset mid-run busy0", 32'(busy0), 32'd0);
            check("reset mid-run array_rst_n", 32'(arst0), 32'd0);
            #2 reset = 1'b1;
            break;
         end
         if (done0) begin
            got_done = 1'b1;
            run_k    = k;
            check("busy0 high with done", 32'(busy0), 32'd1);
            break;
         end
      end
      if (rst_k == 0) begin
         check("done0 seen within bound", 32'(got_done), 32'd1);
         @(posedge clk); #1;
         check("done0 is a single pulse", 32'(done0), 32'd0);
         check("busy0 low after done", 32'(busy0), 32'd0);
      end
   endtask

   task automatic check_c0(input string tag, input int e00, input int e01,
                           input int e10, input int e11);
      check({tag, " C00"}, 32'(c0[0][0]), 32'(e00));
      check({tag, " C01"}, 32'(c0[0][1]), 32'(e01));
      check({tag, " C10"}, 32'(c0[1][0]), 32'(e10));
      check({tag, " C11"}, 32'(c0[1][1]), 32'(e11));
   endtask

   // ---------------- instance 1 helpers ----------------
   logic [7:0]  ma1 [0:2][0:3];
   logic [7:0]  mb1 [0:3][0:1];
   logic [15:0] ref1 [0:2][0:1];

   task automatic write1(input logic sel, input int row, input int col,
                         input logic [7:0] data, input logic exp_drop);
      wr_en1 = 1'b1; wr_sel1 = sel; wr_row1 = 2'(row); wr_col1 = 2'(col); wr_data1 = data;
      @(posedge clk); #1;
      wr_en1 = 1'b0;
      if (exp_drop)
         check($sformatf("wr_drop1 out of range sel%0d r%0d c%0d", sel, row, col),
               32'(wr_drop1), 32'd1);
   endtask

   // Spec stream for the 2x2 example, indexed by FEED cycle t.
   int exp_a0 [0:3] = '{1, 2, 0, 0};
   int exp_a1 [0:3] = '{0, 3, 4, 0};
   int exp_b0 [0:3] = '{5, 7, 0, 0};
   int exp_b1 [0:3] = '{0, 6, 8, 0};

   initial begin
      int dc;
      logic got1;
      int k1;
      reset = 1'b0;
      wr_en0 = 0; wr_sel0 = 0; wr_row0 = 0; wr_col0 = 0; wr_data0 = 0; start0 = 0;
      wr_en1 = 0; wr_sel1 = 0; wr_row1 = 0; wr_col1 = 0; wr_data1 = 0; start1 = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy0", 32'(busy0), 32'd0);
      check("reset done0", 32'(done0), 32'd0);
      check("reset wr_drop0", 32'(wr_drop0), 32'd0);
      check("reset array_rst_n", 32'(arst0), 32'd0);
      check("reset a_out0[1]", 32'(a_out0[1]), 32'd0);
      check("reset b_out0[1]", 32'(b_out0[1]), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("array_rst_n idle", 32'(arst0), 32'd1);

      // Run 1: the spec example, with a write and a start injected during FEED.
      ma0 = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
      mb0 = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}};
      load0();
      dc = done_cnt0;
      run0(3, 0);
      check("done latency run1", 32'(run_k), 32'd7);
      for (int t = 0; t < 4; t++) begin
         check($sformatf("a_out0[0] t%0d", t), 32'(rec_a[t + 2][0]), 32'(exp_a0[t]));
         check($sformatf("a_out0[1] t%0d", t), 32'(rec_a[t + 2][1]), 32'(exp_a1[t]));
         check($sformatf("b_out0[0] t%0d", t), 32'(rec_b[t + 2][0]), 32'(exp_b0[t]));
         check($sformatf("b_out0[1] t%0d", t), 32'(rec_b[t + 2][1]), 32'(exp_b1[t]));
      end
      check_c0("run1", 19, 22, 43, 50);
      repeat (12) @(posedge clk);
      #1;
      check("no second done after busy start", 32'(done_cnt0 - dc), 32'd1);

      // Run 2: B = identity. C = A only if CLEAR wiped the first result.
      mb0 = '{'{8'd1, 8'd0}, '{8'd0, 8'd1}};
      load0();
      run0(0, 0);
      check("done latency run2", 32'(run_k), 32'd7);
      check_c0("run2 identity", 1, 2, 3, 4);

      // Run 3: reset during FEED t=1 aborts the run, then a fresh run.
      mb0 = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}};
      load0();
      dc = done_cnt0;
      run0(0, 2);
      repeat (12) @(posedge clk);
      #1;
      check("no done after aborted run", 32'(done_cnt0 - dc), 32'd0);
      load0();
      run0(0, 0);
      check("done latency after reset", 32'(run_k), 32'd7);
      check_c0("after reset", 19, 22, 43, 50);

      // Instance 1: 3x2, K=4, random data plus out-of-range writes.
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 4; k++) ma1[i][k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 2; j++) mb1[k][j] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 2; j++) begin
            ref1[i][j] = '0;
            for (int k = 0; k < 4; k++)
               ref1[i][j] = ref1[i][j] + 16'(ma1[i][k]) * 16'(mb1[k][j]);
         end
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 4; k++) write1(1'b0, i, k, ma1[i][k], 1'b0);
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 2; j++) write1(1'b1, k, j, mb1[k][j], 1'b0);
      write1(1'b0, 3, 0, 8'hFF, 1'b1);
      write1(1'b1, 0, 2, 8'hFF, 1'b1);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      got1 = 1'b0;
      k1   = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done1) begin
            got1 = 1'b1;
            k1   = k;
            break;
         end
      end
      check("done1 seen within bound", 32'(got1), 32'd1);
      check("done1 latency", 32'(k1), 32'd10);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 2; j++)
            check($sformatf("dut1 C%0d%0d", i, j), 32'(c1[i][j]), 32'(ref1[i][j]));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
